// File: rtl/controlador_de_teclado.sv
// Debounced 10-button digit keypad controller with valid/ack handshake.
// Optional SINCRONIZADOR_EN macro inserts a two-flop input synchronizer ahead of the FSM.
module controlador_de_teclado #(
    parameter int DEBOUNCE_CICLOS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] botoes,
    input  logic       ack,
    output logic [3:0] digito,
    output logic       valido,
    output logic       multiplo,
    output logic       ocupado
);
    localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(DEBOUNCE_CICLOS - 1);

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        FILTRANDO     = 2'd1,
        EMITINDO      = 2'd2,
        ESPERA_SOLTAR = 2'd3
    } estado_t;

    estado_t       estado_r;
    logic [CW-1:0] contador_r;
    logic [9:0]    padrao_r;
    logic [3:0]    indice_r;
    logic [9:0]    amostra_s;
    logic [3:0]    uns_s;

    function automatic logic [3:0] contar_uns(input logic [9:0] v);
        logic [3:0] total;
        total = 4'd0;
        for (int i = 0; i < 10; i++) begin
            total = total + {3'd0, v[i]};
        end
        return total;
    endfunction

    function automatic logic [3:0] indice_de(input logic [9:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

`ifdef SINCRONIZADOR_EN
    logic [9:0] sinc1_r;
    logic [9:0] sinc2_r;

    // Two-stage synchronizer for the asynchronous button levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            sinc1_r <= 10'd0;
            sinc2_r <= 10'd0;
        end else begin
            sinc1_r <= botoes;
            sinc2_r <= sinc1_r;
        end
    end

    assign amostra_s = sinc2_r;
`else
    assign amostra_s = botoes;
`endif

    assign uns_s   = contar_uns(amostra_s);
    assign ocupado = (estado_r != OCIOSO);

    // Keypad FSM: press filtering, emission handshake and release filtering share one counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_r   <= OCIOSO;
            contador_r <= '0;
            padrao_r   <= 10'd0;
            indice_r   <= 4'd0;
            digito     <= 4'd0;
            valido     <= 1'b0;
            multiplo   <= 1'b0;
        end else begin
            multiplo <= 1'b0;
            case (estado_r)
                OCIOSO: begin
                    if (uns_s == 4'd1) begin
                        padrao_r   <= amostra_s;
                        indice_r   <= indice_de(amostra_s);
                        contador_r <= CW'(1);
                        estado_r   <= FILTRANDO;
                    end else if (uns_s > 4'd1) begin
                        multiplo <= 1'b1;
                    end else begin
                        contador_r <= '0;
                    end
                end
                FILTRANDO: begin
                    if (amostra_s == padrao_r) begin
                        if (contador_r == ULTIMO) begin
                            estado_r <= EMITINDO;
                            digito   <= indice_r;
                            valido   <= 1'b1;
                        end else begin
                            contador_r <= contador_r + CW'(1);
                        end
                    end else begin
                        // A bounce or a different key aborts the press without emitting.
                        estado_r   <= OCIOSO;
                        contador_r <= '0;
                        multiplo   <= (uns_s > 4'd1);
                    end
                end
                EMITINDO: begin
                    if (valido && ack) begin
                        valido     <= 1'b0;
                        contador_r <= '0;
                        estado_r   <= ESPERA_SOLTAR;
                    end else begin
                        valido <= valido;
                    end
                end
                ESPERA_SOLTAR: begin
                    if (amostra_s == 10'd0) begin
                        if (contador_r == ULTIMO) begin
                            estado_r   <= OCIOSO;
                            contador_r <= '0;
                        end else begin
                            contador_r <= contador_r + CW'(1);
                        end
                    end else begin
                        contador_r <= '0;
                    end
                end
                default: begin
                    estado_r   <= OCIOSO;
                    contador_r <= '0;
                    valido     <= 1'b0;
                end
            endcase
        end
    end
endmodule
